// File: rtl/reservoir_fill_arbiter.sv
// Shares one supply pump among N reservoirs: urgent-first round-robin grant
// with minimum fill time, fairness cap and a dead-time between valve switchovers.
module reservoir_fill_arbiter #(
    parameter int N      = 4,
    parameter int MIN_ON = 4,
    parameter int MAX_ON = 16,
    parameter int DEAD   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [3*N-1:0]       level,
    output logic [N-1:0]         grant,
    output logic                 valve_open,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 fill_done,
    output logic                 urgent_any
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_ON + 1);
    localparam int DW = $clog2(DEAD + 1);

    localparam logic [CW-1:0] MIN_C  = CW'(MIN_ON);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_ON);
    localparam logic [DW-1:0] DEAD_C = DW'(DEAD);
    localparam logic [DW-1:0] DONE1  = DW'(1);
    localparam logic [IW-1:0] LAST   = IW'(N - 1);
    localparam logic [N-1:0]  ONE    = N'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DEAD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dcnt;
    logic [IW-1:0] rr_ptr;
    logic          urg_fill;

    logic [N-1:0]  req;
    logic [N-1:0]  urg;
    logic [N-1:0]  oth_req;
    logic [N-1:0]  oth_urg;
    logic          cur_full;
    logic          exit_fill;
    logic [IW-1:0] win;
    logic          win_urg;

    // Non-thermometer codes fall out as "requesting, not urgent".
    always_comb begin
        req = '0;
        urg = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = level[3*i +: 3] != 3'b111;
            urg[i] = level[3*i +: 3] == 3'b000;
        end
    end

    always_comb begin
        oth_req  = req & ~grant;
        oth_urg  = urg & ~grant;
        cur_full = |(grant & ~req);
    end

    always_comb begin
        exit_fill = cur_full || !enable;
        if (cnt >= MIN_C && !urg_fill && |oth_urg)
            exit_fill = 1'b1;
        if (cnt >= MAX_C && |oth_req)
            exit_fill = 1'b1;
    end

    // Two-class round-robin search starting just after the last winner.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        logic [IW-1:0] win_u;
        logic [IW-1:0] win_r;
        logic          found_u;
        logic          found_r;
        sum     = '0;
        idx     = '0;
        win_u   = rr_ptr;
        win_r   = rr_ptr;
        found_u = 1'b0;
        found_r = 1'b0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!found_u && urg[idx]) begin
                found_u = 1'b1;
                win_u   = idx;
            end
            if (!found_r && req[idx]) begin
                found_r = 1'b1;
                win_r   = idx;
            end
        end
        win     = found_u ? win_u : win_r;
        win_urg = found_u;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= '0;
            valve_open <= 1'b0;
            grant_id   <= '0;
            fill_done  <= 1'b0;
            urgent_any <= 1'b0;
            cnt        <= '0;
            dcnt       <= '0;
            rr_ptr     <= LAST;
            urg_fill   <= 1'b0;
        end else begin
            fill_done  <= 1'b0;
            urgent_any <= |urg;
            unique case (state)
                S_IDLE: begin
                    if (enable && |req) begin
                        state      <= S_FILL;
                        grant      <= ONE << win;
                        valve_open <= 1'b1;
                        grant_id   <= win;
                        rr_ptr     <= win;
                        cnt        <= CW'(1);
                        urg_fill   <= win_urg;
                    end
                end
                S_FILL: begin
                    if (exit_fill) begin
                        state      <= S_DEAD;
                        grant      <= '0;
                        valve_open <= 1'b0;
                        fill_done  <= cur_full;
                        dcnt       <= DONE1;
                    end else if (cnt != MAX_C) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DEAD: begin
                    if (dcnt >= DEAD_C)
                        state <= S_IDLE;
                    else
                        dcnt <= dcnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reservoir_fill_arbiter.sv
// Directed bench for reservoir_fill_arbiter with a cycle-level behavioural
// model compared every cycle plus hand-computed scenario checkpoints.
module tb_reservoir_fill_arbiter;

    localparam int N      = 4;
    localparam int MIN_ON = 4;
    localparam int MAX_ON = 16;
    localparam int DEAD   = 2;
    localparam int IW     = $clog2(N);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic [3*N-1:0] level = '1;
    logic [N-1:0]   grant;
    logic           valve_open;
    logic [IW-1:0]  grant_id;
    logic           fill_done;
    logic           urgent_any;

    reservoir_fill_arbiter #(
        .N(N), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .DEAD(DEAD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .level(level),
        .grant(grant),
        .valve_open(valve_open),
        .grant_id(grant_id),
        .fill_done(fill_done),
        .urgent_any(urgent_any)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] lv(input int i);
        return level[3*i +: 3];
    endfunction

    // Model: open index (-1 when closed), cycles high so far,
    // cycles closed so far, last winner.
    int m_open = -1;
    int m_high = 0;
    int m_closed = DEAD + 1;
    int m_ptr = N - 1;
    int m_last = 0;
    bit m_fd = 0;
    bit m_ua = 0;
    bit m_ufill = 0;

    function automatic int pick();
        for (int k = 1; k <= N; k++)
            if (lv((m_ptr + k) % N) == 3'b000) return (m_ptr + k) % N;
        for (int k = 1; k <= N; k++)
            if (lv((m_ptr + k) % N) != 3'b111) return (m_ptr + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit o_urg;
        bit o_req;
        bit full_now;
        bit any_req;
        int w;
        if (reset) begin
            m_open   = -1;
            m_high   = 0;
            m_closed = DEAD + 1;
            m_ptr    = N - 1;
            m_last   = 0;
            m_fd     = 0;
            m_ua     = 0;
            m_ufill  = 0;
        end else begin
            m_ua = 0;
            any_req = 0;
            for (int i = 0; i < N; i++) begin
                if (lv(i) == 3'b000) m_ua = 1;
                if (lv(i) != 3'b111) any_req = 1;
            end
            m_fd = 0;
            if (m_open >= 0) begin
                o_urg = 0;
                o_req = 0;
                for (int i = 0; i < N; i++) begin
                    if (i != m_open && lv(i) == 3'b000) o_urg = 1;
                    if (i != m_open && lv(i) != 3'b111) o_req = 1;
                end
                full_now = lv(m_open) == 3'b111;
                if (full_now || !enable
                    || (m_high >= MIN_ON && !m_ufill && o_urg)
                    || (m_high >= MAX_ON && o_req)) begin
                    m_fd = full_now;
                    m_open = -1;
                    m_closed = 1;
                end else begin
                    m_high++;
                end
            end else if (m_closed > DEAD && enable && any_req) begin
                w = pick();
                m_ufill = lv(w) == 3'b000;
                m_open = w;
                m_high = 1;
                m_ptr = w;
                m_last = w;
            end else begin
                m_closed++;
            end
        end
        armed = 1;
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] eg;
        if (armed) begin
            eg = (m_open >= 0) ? (N'(1) << m_open) : '0;
            chk("cycle_outputs",
                32'({grant, valve_open, grant_id, fill_done, urgent_any}),
                32'({eg, m_open >= 0, IW'(m_last), m_fd, m_ua}));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lvl(input int i, input logic [2:0] v);
        level[3*i +: 3] = v;
    endtask

    task automatic all_lvl(input logic [2:0] v);
        for (int i = 0; i < N; i++) set_lvl(i, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int len;
        int gap;

        // Reset values
        tick(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valve", 32'(valve_open), 32'h0);
        chk("rst_id", 32'(grant_id), 32'h0);
        chk("rst_fill_done", 32'(fill_done), 32'h0);
        chk("rst_urgent", 32'(urgent_any), 32'h0);
        reset = 1'b0;

        // No requests
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("idle_quiet", 32'({grant, valve_open, fill_done}), 32'h0);
        end

        // Single requester
        enable = 1'b0;
        set_lvl(2, 3'b011);
        tick(1);
        enable = 1'b1;
        tick(1);
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_id", 32'(grant_id), 32'h2);
        chk("single_valve", 32'(valve_open), 32'h1);
        tick(4);
        set_lvl(2, 3'b111);
        tick(1);
        chk("single_release", 32'(grant), 32'h0);
        chk("single_fill_done", 32'(fill_done), 32'h1);
        set_lvl(2, 3'b011);
        tick(1);
        chk("single_pulse_end", 32'({grant, fill_done}), 32'h0);
        tick(1);
        chk("single_gap", 32'(grant), 32'h0);
        tick(1);
        chk("single_regrant", 32'(grant), 32'h4);
        set_lvl(2, 3'b111);
        tick(6);

        // Round-robin among never-full reservoirs
        reset = 1'b1;
        all_lvl(3'b001);
        tick(2);
        reset = 1'b0;
        t = 0;
        while (!valve_open && t < 20) begin
            tick(1);
            t++;
        end
        for (int g = 0; g < 5; g++) begin
            chk("rr_id", 32'(grant_id), 32'(g % N));
            chk("rr_grant", 32'(grant), 32'(1 << (g % N)));
            len = 0;
            while (valve_open && len < 100) begin
                len++;
                tick(1);
            end
            chk("rr_len", 32'(len), 32'd16);
            if (g < 4) begin
                gap = 0;
                while (!valve_open && gap < 50) begin
                    gap++;
                    tick(1);
                end
                chk("rr_gap", 32'(gap), 32'd3);
            end
        end
        all_lvl(3'b111);
        tick(6);

        // Urgent preemption
        reset = 1'b1;
        set_lvl(0, 3'b011);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("pre_grant0", 32'(grant), 32'h1);
        tick(1);
        chk("pre_urg_low", 32'(urgent_any), 32'h0);
        set_lvl(3, 3'b000);
        tick(1);
        chk("pre_urg_high", 32'(urgent_any), 32'h1);
        chk("pre_held3", 32'(grant), 32'h1);
        tick(1);
        chk("pre_held4", 32'(grant), 32'h1);
        tick(1);
        chk("pre_release", 32'({grant, fill_done}), 32'h0);
        tick(2);
        chk("pre_gap_end", 32'(grant), 32'h0);
        tick(1);
        chk("pre_grant3", 32'(grant), 32'h8);
        chk("pre_id3", 32'(grant_id), 32'h3);
        all_lvl(3'b111);
        tick(6);

        // Enable drop during FILL cycle 7
        reset = 1'b1;
        set_lvl(1, 3'b011);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("en_grant", 32'(grant), 32'h2);
        tick(6);
        chk("en_held", 32'(grant), 32'h2);
        enable = 1'b0;
        tick(1);
        chk("en_release", 32'({grant, fill_done}), 32'h0);
        tick(10);
        chk("en_blocked", 32'({grant, valve_open}), 32'h0);
        enable = 1'b1;
        tick(1);
        chk("en_regrant", 32'(grant), 32'h2);

        // Reset mid-FILL, then reservoir 0 beats reservoir 1
        set_lvl(0, 3'b011);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("midrst_outputs",
            32'({grant, valve_open, grant_id, fill_done, urgent_any}),
            32'h0);
        reset = 1'b0;
        tick(1);
        chk("midrst_grant0", 32'(grant), 32'h1);
        chk("midrst_id0", 32'(grant_id), 32'h0);

        // Full and urgent preemption in the same cycle
        tick(4);
        set_lvl(0, 3'b111);
        set_lvl(2, 3'b000);
        tick(1);
        chk("both_release", 32'(grant), 32'h0);
        chk("both_fill_done", 32'(fill_done), 32'h1);
        tick(1);
        chk("both_pulse_end", 32'(fill_done), 32'h0);
        tick(2);
        chk("both_urgent_win", 32'(grant), 32'h4);
        chk("both_urgent_id", 32'(grant_id), 32'h2);
        all_lvl(3'b111);
        tick(6);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
